lif_frame_sched: RTL and testbench

- Stimulus sequencer for one LIF neuron block. The block takes four 4-bit inputs and produces one 4-bit output.
- Host pushes 16-bit input frames into a small FIFO. The sequencer issues one frame to the block's four inputs at a programmable cycle period.
- For each frame it captures the block output a fixed latency later and flags a spike.
- Sits between the host/IO fabric and the neuron block wrapper. It is the only driver of the block's inputs.

---
 rtl/lif_frame_sched.sv | 156 +++++++++++++++
 tb/tb_lif_frame_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_frame_sched.sv
// Frame sequencer for one LIF neuron block: queues 16-bit host frames, presents one
// frame per programmable period to the block inputs and captures the block output LAT cycles later.
module lif_frame_sched #(
    parameter int         DEPTH    = 4,
    parameter int         LAT      = 2,
    parameter logic [3:0] SPIKE_TH = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  period,
    input  logic        frame_valid,
    input  logic [15:0] frame_data,
    output logic        frame_ready,
    output logic [3:0]  blk_in1,
    output logic [3:0]  blk_in2,
    output logic [3:0]  blk_in3,
    output logic [3:0]  blk_in4,
    input  logic [3:0]  blk_out,
    output logic        res_valid,
    output logic [3:0]  res_data,
    output logic        res_spike,
    output logic        busy,
    output logic [15:0] issued_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Frame storage; contents need no reset because occupancy gates every read.
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_q, rdy_d;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [15:0]   head;

    logic [7:0]    pcnt_q, pcnt_d;
    logic [15:0]   blk_q, blk_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic          vld_tail;

    logic          res_valid_q, res_valid_d;
    logic [3:0]    res_data_q, res_data_d;
    logic          res_spike_q, res_spike_d;
    logic [15:0]   issued_q, issued_d;

    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // Push/pop handshake: a frame is taken only when frame_valid and frame_ready are
    // both high at the clock edge; frame_ready reflects registered occupancy, so a pop
    // in the same cycle never makes room for a push until the following cycle.
    assign push = frame_valid & rdy_q;
    assign pop  = enable & ~fifo_empty & (pcnt_q == 8'd0);

    assign vld_tail = vld_q[LAT-1];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rdy_d = (count_d != FULL_CNT);
    end

    // The period counter free-runs down to zero even while disabled, so re-enabling
    // issues immediately once the previous spacing has elapsed.
    always_comb begin
        pcnt_d = pcnt_q;
        if (pop) begin
            pcnt_d = (period == 8'd0) ? 8'd0 : period - 8'd1;
        end else if (pcnt_q != 8'd0) begin
            pcnt_d = pcnt_q - 8'd1;
        end
    end

    always_comb begin
        blk_d    = pop ? head : 16'd0;
        vld_d    = LAT'({vld_q, pop});
        issued_d = pop ? issued_q + 16'd1 : issued_q;
    end

    // The tail bit marks the cycle blk_out reflects the frame issued LAT cycles earlier.
    always_comb begin
        res_valid_d = vld_tail;
        res_data_d  = res_data_q;
        res_spike_d = 1'b0;
        if (vld_tail) begin
            res_data_d  = blk_out;
            res_spike_d = (blk_out >= SPIKE_TH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdy_q       <= 1'b1;
            pcnt_q      <= 8'd0;
            blk_q       <= 16'd0;
            vld_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'd0;
            res_spike_q <= 1'b0;
            issued_q    <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdy_q       <= rdy_d;
            pcnt_q      <= pcnt_d;
            blk_q       <= blk_d;
            vld_q       <= vld_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_spike_q <= res_spike_d;
            issued_q    <= issued_d;
        end
    end

    assign frame_ready = rdy_q;
    assign blk_in1     = blk_q[3:0];
    assign blk_in2     = blk_q[7:4];
    assign blk_in3     = blk_q[11:8];
    assign blk_in4     = blk_q[15:12];
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_spike   = res_spike_q;
    assign issued_cnt  = issued_q;
    // Busy stays high through the result pulse itself and drops the cycle after.
    assign busy        = ~fifo_empty | (|vld_q) | res_valid_q;

endmodule

// File: tb/tb_lif_frame_sched.sv
// Bench for lif_frame_sched: models the neuron block as in1+in2 with two-cycle latency
// and scoreboards every result against frames accepted by the FIFO.
module tb_lif_frame_sched;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  period = 8'd1;
    logic        frame_valid = 1'b0;
    logic [15:0] frame_data = 16'd0;
    logic        frame_ready;
    logic [3:0]  blk_in1, blk_in2, blk_in3, blk_in4;
    logic [3:0]  blk_out = 4'd0;
    logic        res_valid;
    logic [3:0]  res_data;
    logic        res_spike;
    logic        busy;
    logic [15:0] issued_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          res_seen = 0;
    int          cyc = 0;
    logic [4:0]  exp_q[$];
    int          issue_log[$];
    logic [15:0] last_cnt = 16'd0;

    lif_frame_sched #(.DEPTH(DEPTH), .LAT(LAT), .SPIKE_TH(4'd8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
        .blk_in1(blk_in1), .blk_in2(blk_in2), .blk_in3(blk_in3), .blk_in4(blk_in4),
        .blk_out(blk_out), .res_valid(res_valid), .res_data(res_data),
        .res_spike(res_spike), .busy(busy), .issued_cnt(issued_cnt)
    );

    // clock / reset / block model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) blk_out <= 4'd0;
        else       blk_out <= blk_in1 + blk_in2;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [15:0] f);
        logic [3:0] s;
        s = f[3:0] + f[7:4];
        return {(s >= 4'd8), s};
    endfunction

    // scoreboard + issue logger
    always @(negedge clk) begin
        if (reset) begin
            last_cnt = 16'd0;
        end else begin
            if (issued_cnt != last_cnt) issue_log.push_back(cyc);
            last_cnt = issued_cnt;
            if (res_valid) begin
                res_seen++;
                if (exp_q.size() == 0) check_eq("res_unexpected", {31'd0, res_valid}, 32'd0);
                else check_eq("res", {27'd0, res_spike, res_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; frame_valid = 1'b0; enable = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] d, input bit exp_rdy);
        @(posedge clk); #1;
        check_eq("frame_ready", {31'd0, frame_ready}, {31'd0, exp_rdy});
        frame_valid = 1'b1;
        frame_data  = d;
        if (exp_rdy) exp_q.push_back(model(d));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq("drain_busy", {31'd0, busy}, 32'd0);
        check_eq("drain_exp_q", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] d;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {31'd0, frame_ready}, 32'd1);
        check_eq("rst_blk_in", {16'd0, blk_in4, blk_in3, blk_in2, blk_in1}, 32'd0);
        check_eq("rst_res", {26'd0, res_valid, res_spike, res_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_cnt", {16'd0, issued_cnt}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // single frame, period 1: pulse presentation and result latency
        enable = 1'b1; period = 8'd1;
        frame_valid = 1'b1; frame_data = 16'h4321;
        exp_q.push_back(model(16'h4321));
        @(posedge clk); #1 frame_valid = 1'b0;           // issue cycle
        @(negedge clk);
        check_eq("t1_no_bypass", {28'd0, blk_in1}, 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("t1_blk_in", {16'd0, blk_in4, blk_in3, blk_in2, blk_in1}, 32'h4321);
        check_eq("t1_cnt", {16'd0, issued_cnt}, 32'd1);
        @(negedge clk);
        check_eq("t1_blk_zero", {16'd0, blk_in4, blk_in3, blk_in2, blk_in1}, 32'd0);
        check_eq("t1_res_early", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check_eq("t1_res_pulse", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        check_eq("t1_res_end", {31'd0, res_valid}, 32'd0);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

        // period 3, four back-to-back frames
        period = 8'd3;
        issue_log.delete();
        for (int i = 0; i < 4; i++) push_frame(16'($urandom_range(0, 16'hFFFF)), 1'b1);
        idle();
        wait_idle(100);
        check_eq("t2_issues", issue_log.size(), 32'd4);
        for (int i = 1; i < issue_log.size(); i++)
            check_eq("t2_spacing", issue_log[i] - issue_log[i-1], 32'd3);

        // disabled fill: DEPTH accepted, one dropped, then drain
        do_reset();
        period = 8'd1;
        res_seen = 0;
        for (int i = 0; i <= DEPTH; i++) push_frame(16'($urandom_range(0, 16'hFFFF)), i < DEPTH);
        idle();
        enable = 1'b1;
        wait_idle(100);
        check_eq("t3_results", res_seen, 32'd4);
        check_eq("t3_cnt", {16'd0, issued_cnt}, 32'd4);

        // known block outputs, spike threshold boundary
        push_frame(16'h0035, 1'b1);
        push_frame(16'h0012, 1'b1);
        idle();
        wait_idle(100);

        // full FIFO with simultaneous push attempt and issue
        do_reset();
        period = 8'd1;
        res_seen = 0;
        for (int i = 0; i < DEPTH; i++) push_frame(16'($urandom_range(0, 16'hFFFF)), 1'b1);
        @(posedge clk); #1;
        check_eq("t5_full_ready", {31'd0, frame_ready}, 32'd0);
        enable = 1'b1; frame_valid = 1'b1; frame_data = 16'($urandom_range(0, 16'hFFFF));
        @(posedge clk); #1;
        enable = 1'b0; frame_valid = 1'b0;
        check_eq("t5_ready_after_pop", {31'd0, frame_ready}, 32'd1);
        check_eq("t5_cnt", {16'd0, issued_cnt}, 32'd1);
        push_frame(16'($urandom_range(0, 16'hFFFF)), 1'b1);
        push_frame(16'($urandom_range(0, 16'hFFFF)), 1'b0);
        idle();
        enable = 1'b1;
        wait_idle(100);
        check_eq("t5_results", res_seen, 32'd5);

        // reset with two queued and one in flight
        do_reset();
        period = 8'd8; enable = 1'b1;
        for (int i = 0; i < 3; i++) push_frame(16'($urandom_range(0, 16'hFFFF)), 1'b1);
        @(posedge clk); #1;
        check_eq("t6_cnt_pre", {16'd0, issued_cnt}, 32'd1);
        frame_valid = 1'b0; reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t6_ready", {31'd0, frame_ready}, 32'd1);
        check_eq("t6_blk_in", {16'd0, blk_in4, blk_in3, blk_in2, blk_in1}, 32'd0);
        check_eq("t6_res", {26'd0, res_valid, res_spike, res_data}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_cnt", {16'd0, issued_cnt}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        res_seen = 0;
        repeat (12) @(negedge clk);
        check_eq("t6_no_results", res_seen, 32'd0);
        check_eq("t6_idle", {31'd0, busy}, 32'd0);

        // issued_cnt wrap
        do_reset();
        period = 8'd1; enable = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 65535; i++) begin
            d = 16'($urandom_range(0, 16'hFFFF));
            frame_valid = 1'b1; frame_data = d;
            exp_q.push_back(model(d));
            @(posedge clk); #1;
        end
        frame_valid = 1'b0;
        wait_idle(50);
        check_eq("t7_cnt_max", {16'd0, issued_cnt}, 32'h0000FFFF);
        push_frame(16'($urandom_range(0, 16'hFFFF)), 1'b1);
        idle();
        wait_idle(50);
        check_eq("t7_cnt_wrap", {16'd0, issued_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
